// File: rtl/fir_decim_capture_if.sv
// rtl/fir_decim_capture_if.sv - sample-in / FIFO-out stream bundle for fir_decim_capture
interface fir_decim_capture_if #(
    parameter int DW = 32
);
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;

    // slave: the capture block; master: the FIR source plus downstream consumer
    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/fir_decim_capture.sv
// rtl/fir_decim_capture.sv - decimating frame capture of FIR output into a FWFT FIFO
module fir_decim_capture #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic [7:0]           decim_i,
    input  logic [7:0]           frame_len_i,
    fir_decim_capture_if.slave   s,
    output logic [AW:0]          count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    phase_q, phase_d;
    logic [7:0]    kept_q, kept_d;
    logic [7:0]    decim_q, decim_d;
    logic [7:0]    frame_len_q, frame_len_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic frame_end;
    logic sample_slot;
    logic keep;
    logic push;
    logic pop;
    logic mem_we;

    // Full/empty come from the registered count, so a same-cycle pop never frees room for a push.
    assign full        = (count_q == (AW+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign frame_end   = (kept_q == frame_len_q);
    assign sample_slot = (state_q == ST_CAPTURE) && !frame_end && s.in_valid_i;
    assign keep        = sample_slot && (phase_q == 8'd0);
    assign push        = keep && !full;
    assign pop         = !empty && s.out_ready_i;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        phase_d     = phase_q;
        kept_d      = kept_q;
        decim_d     = decim_q;
        frame_len_d = frame_len_q;
        mem_we      = push;

        if (sample_slot) begin
            phase_d = (phase_q == decim_q - 8'd1) ? 8'd0 : phase_q + 8'd1;
        end

        if (keep) begin
            kept_d = kept_q + 8'd1;
            if (full) begin
                overflow_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_CAPTURE: begin
                // Leave on the edge that records the last kept slot so done follows immediately.
                if (frame_end || (keep && (kept_q + 8'd1 == frame_len_q))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // start_i overrides every push, pop and transition computed above.
        if (start_i) begin
            state_d     = ST_CAPTURE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            phase_d     = 8'd0;
            kept_d      = 8'd0;
            decim_d     = (decim_i == 8'd0) ? 8'd1 : decim_i;
            frame_len_d = frame_len_i;
            mem_we      = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            phase_q     <= 8'd0;
            kept_q      <= 8'd0;
            decim_q     <= 8'd1;
            frame_len_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            phase_q     <= phase_d;
            kept_q      <= kept_d;
            decim_q     <= decim_d;
            frame_len_q <= frame_len_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we && !wb_rst_i) begin
            mem_q[wr_ptr_q] <= s.in_data_i;
        end
    end

    assign s.out_valid_o = !empty;
    assign s.out_data_o  = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign busy_o        = (state_q == ST_CAPTURE);
    assign done_o        = (state_q == ST_DONE);
    assign overflow_o    = overflow_q;

endmodule
